// File: rtl/pmem_line_if.sv
// Cache-line pmem bus plus the 64-bit burst memory bus.
// The responder owns the slave side; the cache and memory side own the master side.
interface pmem_line_if #(
  parameter int s_line = 256,
  parameter int s_beat = 64
);
  // Cache-line side
  logic              pmem_read;
  logic              pmem_write;
  logic [31:0]       pmem_address;
  logic [s_line-1:0] pmem_wdata;
  logic [s_line-1:0] pmem_rdata;
  logic              pmem_resp;

  // Burst memory side
  logic              burst_read;
  logic              burst_write;
  logic [31:0]       burst_address;
  logic [s_beat-1:0] burst_wdata;
  logic [s_beat-1:0] burst_rdata;
  logic              burst_resp;

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  burst_rdata, burst_resp,
    output pmem_rdata, pmem_resp,
    output burst_read, burst_write, burst_address, burst_wdata
  );

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    output burst_rdata, burst_resp,
    input  pmem_rdata, pmem_resp,
    input  burst_read, burst_write, burst_address, burst_wdata
  );
endinterface

// File: rtl/pmem_line_responder.sv
// Cache-line responder: takes one 256-bit line read or write per request and
// moves it as s_beats x s_beat-bit beats over the burst port, then pulses
// pmem_resp for one cycle. The completed read line is kept in a separate
// register, so pmem_rdata only changes when a read finishes.
module pmem_line_responder #(
  parameter int s_offset = 5,
  parameter int s_line   = 256,
  parameter int s_beat   = 64,
  parameter int s_beats  = 4
) (
  input logic        clk,
  input logic        rst_n,
  pmem_line_if.slave bus
);

  localparam int cnt_w = (s_beats > 1) ? $clog2(s_beats) : 1;
  localparam logic [cnt_w-1:0] last_beat = cnt_w'(s_beats - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [cnt_w-1:0]  cnt_r;
  logic [cnt_w-1:0]  cnt_next_s;
  logic [31:0]       addr_r;
  logic [31:0]       addr_next_s;
  logic [s_line-1:0] wline_r;
  logic [s_line-1:0] wline_next_s;
  logic [s_line-1:0] rbuf_r;
  logic [s_line-1:0] rbuf_next_s;
  logic [s_line-1:0] rdata_r;
  logic [s_line-1:0] rdata_next_s;

  // Next-state, beat counter and line buffer updates.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    addr_next_s  = addr_r;
    wline_next_s = wline_r;
    rbuf_next_s  = rbuf_r;
    rdata_next_s = rdata_r;
    case (state_r)
      ST_IDLE: begin
        // Write wins if the cache ever raises both requests together.
        if (bus.pmem_write) begin
          addr_next_s  = {bus.pmem_address[31:s_offset], {s_offset{1'b0}}};
          wline_next_s = bus.pmem_wdata;
          cnt_next_s   = {cnt_w{1'b0}};
          state_next_s = ST_WRITE;
        end else if (bus.pmem_read) begin
          addr_next_s  = {bus.pmem_address[31:s_offset], {s_offset{1'b0}}};
          cnt_next_s   = {cnt_w{1'b0}};
          state_next_s = ST_READ;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_READ: begin
        if (bus.burst_resp) begin
          rbuf_next_s[s_beat*cnt_r +: s_beat] = bus.burst_rdata;
          cnt_next_s = cnt_r + {{(cnt_w-1){1'b0}}, 1'b1};
          if (cnt_r == last_beat) begin
            // Publish the whole line at once, including the beat arriving now.
            rdata_next_s = rbuf_next_s;
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_READ;
          end
        end else begin
          state_next_s = ST_READ;
        end
      end
      ST_WRITE: begin
        if (bus.burst_resp) begin
          cnt_next_s = cnt_r + {{(cnt_w-1){1'b0}}, 1'b1};
          if (cnt_r == last_beat) begin
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_WRITE;
          end
        end else begin
          state_next_s = ST_WRITE;
        end
      end
      ST_DONE: begin
        // The request is not looked at here, so a held request is not taken twice.
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {cnt_w{1'b0}};
      addr_r  <= 32'h0000_0000;
      wline_r <= {s_line{1'b0}};
      rbuf_r  <= {s_line{1'b0}};
      rdata_r <= {s_line{1'b0}};
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      addr_r  <= addr_next_s;
      wline_r <= wline_next_s;
      rbuf_r  <= rbuf_next_s;
      rdata_r <= rdata_next_s;
    end
  end

  // Outputs are decoded purely from registered state.
  assign bus.pmem_resp     = (state_r == ST_DONE);
  assign bus.burst_read    = (state_r == ST_READ);
  assign bus.burst_write   = (state_r == ST_WRITE);
  assign bus.burst_address = addr_r;
  assign bus.burst_wdata   = wline_r[s_beat*cnt_r +: s_beat];
  assign bus.pmem_rdata    = rdata_r;

endmodule
